// File: rtl/synth_pkg.sv
// Shared definitions for the pitch table logic: field widths, sequencer
// state encoding and the default pitch datapath latency.
package synth_pkg;

    localparam int PKG_V_WIDTH  = 3;
    localparam int PKG_O_WIDTH  = 2;
    localparam int PKG_OE_WIDTH = 1;
    localparam int PKG_LATENCY  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/tag_pipe.sv
// Fixed-depth delay line of {valid, data} tags that follows indices through
// the pitch datapath so each result can be matched to its table address.
module tag_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];

    // Shift register; only the valid bits matter after reset, data is cleared for determinism.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                data_r[i]  <= {WIDTH{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/pitch_sequencer.sv
// Sweeps every {voice, osc} index through the pitch datapath once per frame
// and writes each returned pitch into the pitch table at the matching address.
module pitch_sequencer
    import synth_pkg::*;
#(
    parameter int VOICES   = 8,
    parameter int V_OSC    = 4,
    parameter int V_WIDTH  = PKG_V_WIDTH,
    parameter int O_WIDTH  = PKG_O_WIDTH,
    parameter int OE_WIDTH = PKG_OE_WIDTH,
    parameter int E_WIDTH  = O_WIDTH + OE_WIDTH,
    parameter int LATENCY  = PKG_LATENCY
) (
    input  logic                        reg_clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        clr_overrun,
    output logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
    input  logic [23:0]                 osc_pitch_val,
    output logic                        pv_we,
    output logic [V_WIDTH+O_WIDTH-1:0]  pv_adr,
    output logic [23:0]                 pv_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int             IW         = V_WIDTH + O_WIDTH;
    localparam logic [IW-1:0]  LAST_IDX   = IW'(VOICES * V_OSC - 1);
    localparam logic [3:0]     DRAIN_LAST = 4'(LATENCY - 1);

    seq_state_t    state_r, state_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [3:0]    drain_cnt_r, drain_cnt_s;
    logic          overrun_set_s;
    logic          tail_valid_s;
    logic [IW-1:0] tail_adr_s;

    // The index register doubles as the datapath index, so it naturally holds outside ISSUE.
    assign xxxx = {idx_r, {OE_WIDTH{1'b0}}};

    // Any start request the FSM cannot honour right now counts as an overrun.
    assign overrun_set_s = frame_start && (state_r != IDLE);

    // Next-state, index and drain counter logic.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        drain_cnt_s = drain_cnt_r;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s = ISSUE;
                    idx_s   = {IW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (idx_r == LAST_IDX) begin
                    state_s     = DRAIN;
                    drain_cnt_s = 4'd0;
                end else begin
                    idx_s = idx_r + IW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_s = DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, index, status flags and overrun bookkeeping.
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= {IW{1'b0}};
            drain_cnt_r <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            drain_cnt_r <= drain_cnt_s;
            busy        <= (state_r == ISSUE) || (state_r == DRAIN);
            done        <= (state_r == DONE);
            if (overrun_set_s) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Tag input is taken from registered state/index so it lines up with xxxx.
    tag_pipe #(
        .DEPTH (LATENCY),
        .WIDTH (IW)
    ) u_tag_pipe (
        .clk       (reg_clk),
        .reset     (reset),
        .in_valid  (state_r == ISSUE),
        .in_data   (idx_r),
        .out_valid (tail_valid_s),
        .out_data  (tail_adr_s)
    );

    // Pitch table write port; the address and data hold between writes.
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            pv_we   <= 1'b0;
            pv_adr  <= {IW{1'b0}};
            pv_data <= 24'd0;
        end else begin
            pv_we <= tail_valid_s;
            if (tail_valid_s) begin
                pv_adr  <= tail_adr_s;
                pv_data <= osc_pitch_val;
            end
        end
    end

endmodule

// File: tb/tb_pitch_sequencer.sv
// Directed bench: three sequencers (LATENCY 4, 1, 15) share stimulus, each with
// its own delayed datapath model; a negedge monitor checks every table write.
module tb_pitch_sequencer;

    localparam int NI = 3;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        clr_overrun;
    logic        fs_mask [NI];
    logic        fs_a    [NI];
    logic [5:0]  xxxx_a  [NI];
    logic [23:0] osc_a   [NI];
    logic        pv_we_a [NI];
    logic [4:0]  pv_adr_a[NI];
    logic [23:0] pv_data_a[NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic        ovr_a   [NI];
    logic [5:0]  pipe    [NI][15];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sweep_id = 0;
    int seen_id = 0;
    int sweep_start = 0;
    bit allow = 1'b0;
    int wr_cnt  [NI];
    int done_cnt[NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        pitch_sequencer #(.LATENCY(lat_of(g))) u_dut (
            .reg_clk       (clk),
            .reset         (reset),
            .frame_start   (fs_a[g]),
            .clr_overrun   (clr_overrun),
            .xxxx          (xxxx_a[g]),
            .osc_pitch_val (osc_a[g]),
            .pv_we         (pv_we_a[g]),
            .pv_adr        (pv_adr_a[g]),
            .pv_data       (pv_data_a[g]),
            .busy          (busy_a[g]),
            .done          (done_a[g]),
            .overrun       (ovr_a[g])
        );
    end

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            fs_a[g]  = frame_start & fs_mask[g];
            osc_a[g] = 24'h100000 + {18'd0, pipe[g][lat_of(g)-1]};
        end
    end

    // Pitch datapath model: xxxx delayed by LATENCY clocks.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            pipe[g][0] <= xxxx_a[g];
            for (int i = 1; i < 15; i++) pipe[g][i] <= pipe[g][i-1];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep();
        sweep_id++;
        sweep_start = cyc + 1;
        allow = 1'b1;
        frame_start = 1'b1;
    endtask

    // Write/done monitor: address order, data, timing and absence outside a sweep.
    initial begin
        forever begin
            @(negedge clk);
            if (seen_id != sweep_id) begin
                seen_id = sweep_id;
                for (int g = 0; g < NI; g++) begin
                    wr_cnt[g] = 0;
                    done_cnt[g] = 0;
                end
            end
            for (int g = 0; g < NI; g++) begin
                if (!allow || wr_cnt[g] >= 32) begin
                    chk_eq($sformatf("we_outside_l%0d", lat_of(g)), {31'd0, pv_we_a[g]}, 32'd0);
                end else if (pv_we_a[g] === 1'b1) begin
                    chk_eq($sformatf("wr_adr_l%0d", lat_of(g)), {27'd0, pv_adr_a[g]}, wr_cnt[g]);
                    chk_eq($sformatf("wr_data_l%0d", lat_of(g)), {8'd0, pv_data_a[g]},
                           32'h100000 + 32'(wr_cnt[g] * 2));
                    chk_eq($sformatf("wr_time_l%0d", lat_of(g)), cyc,
                           sweep_start + wr_cnt[g] + lat_of(g) + 1);
                    wr_cnt[g]++;
                end
                if (!allow) begin
                    chk_eq($sformatf("done_outside_l%0d", lat_of(g)), {31'd0, done_a[g]}, 32'd0);
                end else if (done_a[g] === 1'b1) begin
                    chk_eq($sformatf("done_time_l%0d", lat_of(g)), cyc, sweep_start + 33 + lat_of(g));
                    chk_eq($sformatf("done_wrs_l%0d", lat_of(g)), wr_cnt[g], 32);
                    done_cnt[g]++;
                end
            end
        end
    end

    task automatic chk_sweep_end(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk_eq($sformatf("%s_wrs_l%0d", tag, lat_of(g)), wr_cnt[g], 32);
            chk_eq($sformatf("%s_dones_l%0d", tag, lat_of(g)), done_cnt[g], 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        clr_overrun = 1'b0;
        for (int g = 0; g < NI; g++) fs_mask[g] = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_eq("rst_busy", {31'd0, busy_a[0]}, 32'd0);
        chk_eq("rst_done", {31'd0, done_a[0]}, 32'd0);
        chk_eq("rst_ovr", {31'd0, ovr_a[0]}, 32'd0);
        chk_eq("rst_xxxx", {26'd0, xxxx_a[0]}, 32'd0);
        chk_eq("rst_adr", {27'd0, pv_adr_a[0]}, 32'd0);
        chk_eq("rst_data", {8'd0, pv_data_a[0]}, 32'd0);

        // Plain sweep.
        start_sweep();
        tick();
        frame_start = 1'b0;
        chk_eq("busy_t0", {31'd0, busy_a[0]}, 32'd0);
        tick();
        chk_eq("busy_t1", {31'd0, busy_a[0]}, 32'd1);
        repeat (60) tick();
        chk_sweep_end("s1");
        chk_eq("s1_ovr", {31'd0, ovr_a[0]}, 32'd0);
        chk_eq("s1_xxxx_hold", {26'd0, xxxx_a[0]}, 32'd62);
        chk_eq("s1_busy_end", {31'd0, busy_a[0]}, 32'd0);

        // Start request at sweep cycle 10, then clear.
        start_sweep();
        tick();
        frame_start = 1'b0;
        repeat (9) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_eq("ovr_set", {31'd0, ovr_a[0]}, 32'd1);
        repeat (60) tick();
        chk_sweep_end("s2");
        chk_eq("ovr_sticky", {31'd0, ovr_a[0]}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk_eq("ovr_clr", {31'd0, ovr_a[0]}, 32'd0);

        // Set beats clear; then a request landing on the DONE cycle of LATENCY=4.
        start_sweep();
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        frame_start = 1'b1;
        tick();
        chk_eq("ovr_set2", {31'd0, ovr_a[0]}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        frame_start = 1'b0;
        clr_overrun = 1'b0;
        chk_eq("ovr_set_wins", {31'd0, ovr_a[0]}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk_eq("ovr_clr2", {31'd0, ovr_a[0]}, 32'd0);
        repeat (31) tick();
        fs_mask[1] = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fs_mask[1] = 1'b1;
        chk_eq("ovr_on_done", {31'd0, ovr_a[0]}, 32'd1);
        repeat (60) tick();
        chk_sweep_end("s3");
        chk_eq("s3_no_restart", {31'd0, busy_a[0]}, 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // Reset at sweep cycle 15 (with a simultaneous start request), then a fresh sweep.
        start_sweep();
        tick();
        frame_start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        frame_start = 1'b1;
        tick();
        allow = 1'b0;
        reset = 1'b0;
        frame_start = 1'b0;
        repeat (60) tick();
        for (int g = 0; g < NI; g++) begin
            chk_eq($sformatf("abort_dones_l%0d", lat_of(g)), done_cnt[g], 0);
            chk_eq($sformatf("abort_busy_l%0d", lat_of(g)), {31'd0, busy_a[g]}, 32'd0);
            chk_eq($sformatf("abort_ovr_l%0d", lat_of(g)), {31'd0, ovr_a[g]}, 32'd0);
        end
        start_sweep();
        tick();
        frame_start = 1'b0;
        repeat (60) tick();
        chk_sweep_end("s4");

        // Start held for three cycles.
        start_sweep();
        repeat (3) tick();
        frame_start = 1'b0;
        chk_eq("held_ovr", {31'd0, ovr_a[0]}, 32'd1);
        repeat (60) tick();
        chk_sweep_end("s5");
        chk_eq("held_busy_end", {31'd0, busy_a[0]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
